// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   - State encoding localparams and the FSM state enum.
//   - cnt_w(): width of a burst beat counter able to hold 0..max_burst.
package ram_port_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_OWN0 = OWN0,
    ST_OWN1 = OWN1
  } state_e;

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   vld_i    : request valid bits, one per port
//   rr_ptr_i : preferred port when both are valid
//   gnt_o    : one-hot grant (all zero when nothing is valid)
module rr_pick2 (
  input  logic [1:0] vld_i,
  input  logic       rr_ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = vld_i;
    if (vld_i == 2'b11) gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between two clients
// with round-robin arbitration and burst ownership of up to MAX_BURST beats.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/we/last/addr/wdata, reqN_ready : client N beat handshake
//   rspN_valid, rspN_rdata   : read response for client N (1 cycle after accept)
//   ram_we, ram_addr, ram_din: RAM drive (sampled at the accept edge)
//   ram_dout                 : RAM registered read data
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic                  req0_last,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic                  req1_last,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int            CW      = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    rsp_sel_q, rsp_sel_d;

  logic [1:0] vld, pick, gnt, acc;
  logic       sel_we, sel_last, own;

  assign vld = {req1_valid, req0_valid};

  rr_pick2 u_pick (
    .vld_i    (vld),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick)
  );

  // The owner keeps the grant even with valid low; that cycle ends the burst.
  always_comb begin
    gnt = pick;
    case (state_q)
      ST_OWN0: gnt = 2'b01;
      ST_OWN1: gnt = 2'b10;
      default: gnt = pick;
    endcase
  end

  assign req0_ready = gnt[0] & ~rst;
  assign req1_ready = gnt[1] & ~rst;
  assign acc        = vld & gnt & {2{~rst}};

  assign ram_addr = gnt[1] ? req1_addr  : req0_addr;
  assign ram_din  = gnt[1] ? req1_wdata : req0_wdata;
  assign sel_we   = gnt[1] ? req1_we    : req0_we;
  assign sel_last = gnt[1] ? req1_last  : req0_last;
  assign ram_we   = (|acc) & sel_we;

  assign own     = (state_q == ST_OWN1);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    rsp_sel_d = acc & ~{req1_we, req0_we};
    case (state_q)
      ST_IDLE: begin
        if (|acc) begin
          if (!sel_last && MAX_BURST > 1) begin
            state_d = acc[1] ? ST_OWN1 : ST_OWN0;
            cnt_d   = CW'(1);
          end else begin
            rr_ptr_d = acc[0];  // single-beat grant: prefer the other port
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        // One exit path covers both last and counter-full, so a last beat at
        // MAX_BURST-1 flips the pointer only once.
        if (!vld[own] || (|acc && (sel_last || cnt_inc == CNT_MAX))) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          rr_ptr_d = ~own;
        end else if (|acc) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      rsp_sel_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      rsp_sel_q <= rsp_sel_d;
    end
  end

  // Gating with rst drops a response that is pending when reset arrives.
  assign rsp0_valid = rsp_sel_q[0] & ~rst;
  assign rsp1_valid = rsp_sel_q[1] & ~rst;
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;

endmodule
